// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the RAM arbiter slice.
// Parameter defaults, requester count and controller states.
package ram_ctrl_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 4;
  localparam int DEPTH     = 4;
  localparam int INIT_BASE = 2;
  localparam int NREQ      = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: req/we/addr/wdata in,
// gnt/rvalid/rdata/err out. Requester i uses slice i of packed fields.
interface ram_arbiter_if #(
  parameter int AW = ram_ctrl_pkg::ADDR_W,
  parameter int DW = ram_ctrl_pkg::DATA_W
);
  import ram_ctrl_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant: req_i, ptr_i (favoured id), en_i in;
// one-hot-or-zero gnt_o out. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (1'b1)
        (req_i == 2'b11): gnt_o = ptr_i ? 2'b10 : 2'b01;
        default:          gnt_o = req_i;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Owns the single-port RAM: preloads it after reset or init_start,
// then grants one op per cycle round-robin. Ports: clk, rst,
// requester bus (slave), init_start, busy, ram_addr/wr/din, ram_dout.
module ram_arbiter #(
  parameter int ADDR_W    = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W    = ram_ctrl_pkg::DATA_W,
  parameter int DEPTH     = ram_ctrl_pkg::DEPTH,
  parameter int INIT_BASE = ram_ctrl_pkg::INIT_BASE
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  input  logic              init_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  import ram_ctrl_pkg::*;

  localparam logic [ADDR_W:0] LIM =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH-1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ptr_q;

  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_wr_q;
  logic [DATA_W-1:0] ram_din_q;

  // stage 1: op on the RAM bus
  logic              p1_rd_q;
  logic              p1_err_q;
  logic              p1_id_q;

  // stage 2: response to requester
  logic [1:0]        rvalid_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              acc;
  logic              sel_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;

  assign arb_en = (state_q == ST_RUN) && !init_start;

  rr_arb2 u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign acc      = |gnt;
  assign sel_id   = gnt[1];
  assign sel_we   = sel_id ? bus.we[1] : bus.we[0];
  assign sel_addr = sel_id ? bus.addr[2*ADDR_W-1:ADDR_W]
                           : bus.addr[ADDR_W-1:0];
  assign sel_data = sel_id ? bus.wdata[2*DATA_W-1:DATA_W]
                           : bus.wdata[DATA_W-1:0];
  assign sel_ok   = {1'b0, sel_addr} < LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_din_q  <= '0;
      p1_rd_q    <= 1'b0;
      p1_err_q   <= 1'b0;
      p1_id_q    <= 1'b0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      // idle bus unless a preload or valid op claims it
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_din_q  <= '0;

      p1_rd_q  <= acc && sel_ok && !sel_we;
      p1_err_q <= acc && !sel_ok;
      p1_id_q  <= sel_id;

      rvalid_q <= {p1_id_q, !p1_id_q} & {2{p1_rd_q}};
      err_q    <= {p1_id_q, !p1_id_q} & {2{p1_err_q}};
      if (p1_rd_q)
        rdata_q <= ram_dout;

      if (acc)
        ptr_q <= gnt[0];

      unique case (state_q)
        ST_INIT: begin
          ram_addr_q <= cnt_q;
          ram_wr_q   <= 1'b1;
          ram_din_q  <= DATA_W'(INIT_BASE) + DATA_W'(cnt_q);
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (init_start) begin
            cnt_q   <= '0;
            state_q <= ST_INIT;
          end else if (acc && sel_ok) begin
            ram_addr_q <= sel_addr;
            ram_wr_q   <= sel_we;
            ram_din_q  <= sel_data;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign busy       = (state_q == ST_INIT);
  assign ram_addr   = ram_addr_q;
  assign ram_wr     = ram_wr_q;
  assign ram_din    = ram_din_q;
  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a negedge 4x4 RAM model.
// One task per scenario; prints a single Result line.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       init_start;
  logic       busy;
  logic [2:0] ram_addr;
  logic       ram_wr;
  logic [3:0] ram_din;
  logic [3:0] ram_dout;
  logic [3:0] mem [4];

  int errors = 0;
  int checks = 0;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .init_start (init_start),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_wr     (ram_wr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_wr) mem[ram_addr[1:0]] <= ram_din;
    else        ram_dout <= mem[ram_addr[1:0]];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req   = 2'b00;
    bus.we    = 2'b00;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_start = 1'b0;
    idle_bus();
    cyc();
    cyc();
    #3;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_busy got=%0h exp=1", busy);
    end
    checks++;
    if ({ram_wr, ram_addr, ram_din} !== 8'h00) begin
      errors++;
      $display("FAIL rst_bus got=%0h/%0h/%0h exp=0",
               ram_wr, ram_addr, ram_din);
    end
    checks++;
    if ({bus.rvalid, bus.err, bus.rdata, bus.gnt} !== 10'h0) begin
      errors++;
      $display("FAIL rst_outs rv=%0h er=%0h rd=%0h g=%0h exp=0",
               bus.rvalid, bus.err, bus.rdata, bus.gnt);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_preload();
    #3;
    checks++;
    if (busy !== 1'b1 || ram_wr !== 1'b0) begin
      errors++;
      $display("FAIL pre_c0 busy=%0h wr=%0h exp=1/0", busy, ram_wr);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      #3;
      checks++;
      if (ram_wr !== 1'b1 || ram_addr !== 3'(i)
          || ram_din !== 4'(2 + i)) begin
        errors++;
        $display("FAIL pre_wr%0d got=%0h/%0h/%0h exp=1/%0h/%0h",
                 i, ram_wr, ram_addr, ram_din, i, 2 + i);
      end
      checks++;
      if (busy !== (i < 3)) begin
        errors++;
        $display("FAIL pre_busy%0d got=%0h exp=%0h", i, busy, i < 3);
      end
    end
    // alternate requesters so the pointer ends back at 0
    for (int i = 0; i < 4; i++) begin
      logic [1:0] oh;
      oh = (i % 2) ? 2'b10 : 2'b01;
      bus.req  = oh;
      bus.we   = 2'b00;
      bus.addr = {3'(i), 3'(i)};
      #3;
      checks++;
      if (bus.gnt !== oh) begin
        errors++;
        $display("FAIL rd%0d_gnt got=%0h exp=%0h", i, bus.gnt, oh);
      end
      cyc();
      idle_bus();
      #3;
      checks++;
      if (ram_wr !== 1'b0 || ram_addr !== 3'(i)) begin
        errors++;
        $display("FAIL rd%0d_bus got=%0h/%0h exp=0/%0h",
                 i, ram_wr, ram_addr, i);
      end
      cyc();
      #3;
      checks++;
      if (bus.rvalid !== oh || bus.rdata !== 4'(2 + i)) begin
        errors++;
        $display("FAIL rd%0d_data got=%0h/%0h exp=%0h/%0h",
                 i, bus.rvalid, bus.rdata, oh, 2 + i);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10;
    seq[2] = 2'b01; seq[3] = 2'b10;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        bus.req  = 2'b11;
        bus.we   = 2'b00;
        bus.addr = {3'd1, 3'd1};
      end else begin
        idle_bus();
      end
      #3;
      if (k < 4) begin
        checks++;
        if (bus.gnt !== seq[k]) begin
          errors++;
          $display("FAIL rr_gnt%0d got=%0h exp=%0h", k, bus.gnt, seq[k]);
        end
      end
      if (k >= 2) begin
        checks++;
        if (bus.rvalid !== seq[k-2] || bus.rdata !== 4'h3) begin
          errors++;
          $display("FAIL rr_rv%0d got=%0h/%0h exp=%0h/3",
                   k, bus.rvalid, bus.rdata, seq[k-2]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    bus.req   = 2'b01;
    bus.we    = 2'b01;
    bus.addr  = {3'd0, 3'd2};
    bus.wdata = {4'h0, 4'hA};
    #3;
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++; $display("FAIL b2b_wgnt got=%0h exp=1", bus.gnt);
    end
    cyc();
    bus.req   = 2'b10;
    bus.we    = 2'b00;
    bus.addr  = {3'd2, 3'd0};
    bus.wdata = '0;
    #3;
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++; $display("FAIL b2b_rgnt got=%0h exp=2", bus.gnt);
    end
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== 3'd2 || ram_din !== 4'hA) begin
      errors++;
      $display("FAIL b2b_wbus got=%0h/%0h/%0h exp=1/2/a",
               ram_wr, ram_addr, ram_din);
    end
    cyc();
    idle_bus();
    cyc();
    #3;
    checks++;
    if (bus.rvalid !== 2'b10 || bus.rdata !== 4'hA) begin
      errors++;
      $display("FAIL b2b_rd got=%0h/%0h exp=2/a", bus.rvalid, bus.rdata);
    end
    cyc();
  endtask

  task automatic test_bad_addr();
    bus.req  = 2'b10;
    bus.we   = 2'b00;
    bus.addr = {3'd5, 3'd0};
    #3;
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++; $display("FAIL bad_gnt got=%0h exp=2", bus.gnt);
    end
    cyc();
    idle_bus();
    #3;
    checks++;
    if (ram_wr !== 1'b0 || ram_addr !== 3'd0 || ram_din !== 4'd0) begin
      errors++;
      $display("FAIL bad_bus got=%0h/%0h/%0h exp=0/0/0",
               ram_wr, ram_addr, ram_din);
    end
    cyc();
    #3;
    checks++;
    if (bus.err !== 2'b10 || bus.rvalid !== 2'b00) begin
      errors++;
      $display("FAIL bad_err got=%0h/%0h exp=2/0", bus.err, bus.rvalid);
    end
    cyc();
    #3;
    checks++;
    if (bus.err !== 2'b00) begin
      errors++; $display("FAIL bad_pulse got=%0h exp=0", bus.err);
    end
  endtask

  task automatic test_init_rerun();
    cyc();
    bus.req   = 2'b01;
    bus.we    = 2'b01;
    bus.addr  = {3'd0, 3'd0};
    bus.wdata = {4'h0, 4'hF};
    #3;
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++; $display("FAIL ini_wgnt got=%0h exp=1", bus.gnt);
    end
    cyc();
    idle_bus();
    cyc();
    init_start = 1'b1;
    bus.req    = 2'b01;
    #3;
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++; $display("FAIL ini_pulse_gnt got=%0h exp=0", bus.gnt);
    end
    cyc();
    init_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      checks++;
      if (busy !== 1'b1 || bus.gnt !== 2'b00) begin
        errors++;
        $display("FAIL ini_busy%0d got=%0h/%0h exp=1/0",
                 k, busy, bus.gnt);
      end
      cyc();
    end
    #3;
    checks++;
    if (busy !== 1'b0 || bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL ini_done got=%0h/%0h exp=0/1", busy, bus.gnt);
    end
    cyc();
    idle_bus();
    cyc();
    #3;
    checks++;
    if (bus.rvalid !== 2'b01 || bus.rdata !== 4'h2) begin
      errors++;
      $display("FAIL ini_rd got=%0h/%0h exp=1/2", bus.rvalid, bus.rdata);
    end
    cyc();
  endtask

  task automatic test_reset_midflight();
    bus.req  = 2'b01;
    bus.we   = 2'b00;
    bus.addr = {3'd0, 3'd1};
    #3;
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++; $display("FAIL mid_gnt got=%0h exp=1", bus.gnt);
    end
    cyc();
    idle_bus();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 3'd0
        || bus.rvalid !== 2'b00 || bus.rdata !== 4'd0) begin
      errors++;
      $display("FAIL mid_rst got=%0h/%0h/%0h/%0h/%0h exp=1/0/0/0/0",
               busy, ram_wr, ram_addr, bus.rvalid, bus.rdata);
    end
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #3;
      checks++;
      if (ram_wr !== 1'b1 || ram_addr !== 3'(i)
          || ram_din !== 4'(2 + i) || bus.rvalid !== 2'b00) begin
        errors++;
        $display("FAIL mid_pre%0d got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/0",
                 i, ram_wr, ram_addr, ram_din, bus.rvalid, i, 2 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_round_robin();
    test_back_to_back();
    test_bad_addr();
    test_init_rerun();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
